// File: rtl/garduino_sys_v1_sys_cpu_v2_oci_trace_monitor.sv
// OCI trace monitor: captures DCT entries into a FIFO, tracks the test end
// handshake and drains the captured entries to the debug readout port.
module garduino_sys_v1_sys_cpu_v2_oci_trace_monitor #(
    parameter int DCT_WIDTH   = 30,
    parameter int COUNT_WIDTH = 4,
    parameter int DEPTH       = 16,
    parameter int WRAP_MODE   = 0
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               clear,
    input  logic                               dct_valid,
    input  logic [DCT_WIDTH-1:0]               dct_buffer,
    input  logic [COUNT_WIDTH-1:0]             dct_count,
    input  logic                               test_ending,
    input  logic                               test_has_ended,
    input  logic                               rd_req,
    output logic [DCT_WIDTH+COUNT_WIDTH-1:0]   rd_data,
    output logic                               rd_valid,
    output logic [$clog2(DEPTH):0]             level,
    output logic                               overflow,
    output logic [15:0]                        drop_count,
    output logic [15:0]                        beat_sum,
    output logic [1:0]                         state,
    output logic                               done
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = DCT_WIDTH + COUNT_WIDTH;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_ENDING  = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [EW-1:0] rd_data_q, rd_data_d;
    logic          rd_valid_q, rd_valid_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d, beat_q, beat_d;
    state_t        state_q, state_d;
    logic          pend_q, pend_d;

    logic full, empty, wr_req, rd_en, wr_drop, wr_store, pop;

    always_comb begin
        full     = (level_q == LW'(DEPTH));
        empty    = (level_q == '0);
        wr_req   = !clear && (state_q == ST_CAPTURE) && dct_valid && (dct_count != '0);
        rd_en    = !clear && rd_req && !empty;
        wr_drop  = wr_req && full && !rd_en;
        // In overwrite mode a full-FIFO write still stores; the oldest entry is popped instead.
        wr_store = wr_req && !(wr_drop && (WRAP_MODE == 0));
        pop      = rd_en || (wr_drop && (WRAP_MODE != 0));

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        beat_d     = beat_q;
        state_d    = state_q;
        pend_d     = pend_q;

        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            drop_d     = '0;
            beat_d     = '0;
            state_d    = ST_CAPTURE;
            pend_d     = 1'b0;
        end else begin
            rd_valid_d = rd_en;
            if (rd_en) begin
                rd_data_d = mem[rd_ptr_q];
            end
            if (wr_store) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                beat_d   = beat_q + 16'(dct_count);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (wr_store && !pop) begin
                level_d = level_q + 1'b1;
            end else if (pop && !wr_store) begin
                level_d = level_q - 1'b1;
            end
            if (wr_drop) begin
                overflow_d = 1'b1;
                if (drop_q != 16'hFFFF) begin
                    drop_d = drop_q + 16'd1;
                end
            end

            unique case (state_q)
                ST_CAPTURE: begin
                    // test_has_ended alone implies test_ending; remember it so ENDING moves on unprompted.
                    if (test_ending || test_has_ended) begin
                        state_d = ST_ENDING;
                        pend_d  = test_has_ended;
                    end
                end
                ST_ENDING: begin
                    if (test_has_ended || pend_q) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (empty) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_DONE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_store) begin
            mem[wr_ptr_q] <= {dct_count, dct_buffer};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
            beat_q     <= '0;
            state_q    <= ST_CAPTURE;
            pend_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
            beat_q     <= beat_d;
            state_q    <= state_d;
            pend_q     <= pend_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign level      = level_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;
    assign beat_sum   = beat_q;
    assign state      = state_q;
    assign done       = (state_q == ST_DONE);
endmodule
